// File: rtl/approx_mult_pipe_if.sv
// Operand/result bus of the approximate multiplier pipeline.
// Upstream (operand FIFO) and downstream (accumulator) handshakes share one bundle.
interface approx_mult_pipe_if #(
    parameter int N  = 8,
    parameter int CW = 16
);
    logic              in_valid;
    logic              in_ready;
    logic [N-1:0]      x;
    logic [N-1:0]      y;
    logic              approx_en;
    logic              out_valid;
    logic              out_ready;
    logic [2*N-1:0]    z;
    logic              z_approx;
    logic [CW-1:0]     op_count;

    // The multiplier itself sits on the slave side.
    modport slave (
        input  in_valid, x, y, approx_en, out_ready,
        output in_ready, out_valid, z, z_approx, op_count
    );

    modport master (
        output in_valid, x, y, approx_en, out_ready,
        input  in_ready, out_valid, z, z_approx, op_count
    );
endinterface

// File: rtl/approx_mult_pipe.sv
// Two-stage unsigned N x N multiplier, exact or low-column-OR approximate per beat,
// with valid/ready on both sides and a saturating count of delivered results.
module approx_mult_pipe #(
    parameter int N  = 8,
    parameter int K  = 8,
    parameter int CW = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    approx_mult_pipe_if.slave bus
);
    localparam int           W        = 2 * N;
    localparam logic [W-1:0] ONES     = '1;
    localparam logic [W-1:0] LO_MASK  = ONES >> (W - K);
    localparam logic [CW-1:0] CNT_MAX = '1;

    // Handshake: a beat moves on a side whenever valid & ready are both high at
    // the clock edge; the holder keeps valid and data stable until then.

    logic [W-1:0]  row;
    logic [W-1:0]  hi_sum;
    logic [W-1:0]  lo_exact;
    logic [W-1:0]  lo_or;
    logic [W-1:0]  lo_sel;

    logic          s1_valid_q, s1_valid_d;
    logic [W-1:0]  s1_hi_q, s1_hi_d;
    logic [W-1:0]  s1_lo_q, s1_lo_d;
    logic          s1_approx_q, s1_approx_d;
    logic          out_valid_q, out_valid_d;
    logic [W-1:0]  z_q, z_d;
    logic          z_approx_q, z_approx_d;
    logic [CW-1:0] op_count_q, op_count_d;

    logic          in_fire;
    logic          out_fire;
    logic          s1_adv;

    // Each shifted row holds one partial-product bit per column, so masking rows
    // before summing splits the column sums at K without changing their weight.
    always_comb begin
        row      = '0;
        hi_sum   = '0;
        lo_exact = '0;
        lo_or    = '0;
        for (int j = 0; j < N; j++) begin
            row      = {{N{1'b0}}, bus.x & {N{bus.y[j]}}} << j;
            hi_sum   = hi_sum + (row & ~LO_MASK);
            lo_exact = lo_exact + (row & LO_MASK);
            lo_or    = lo_or | (row & LO_MASK);
        end
        lo_sel = bus.approx_en ? lo_or : lo_exact;
    end

    assign out_fire = out_valid_q && bus.out_ready;
    assign s1_adv   = s1_valid_q && (!out_valid_q || bus.out_ready);
    assign bus.in_ready = !rst_n || !s1_valid_q || s1_adv;
    assign in_fire  = bus.in_valid && bus.in_ready;

    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_hi_d     = s1_hi_q;
        s1_lo_d     = s1_lo_q;
        s1_approx_d = s1_approx_q;
        out_valid_d = out_valid_q;
        z_d         = z_q;
        z_approx_d  = z_approx_q;
        op_count_d  = op_count_q;

        if (in_fire) begin
            s1_valid_d  = 1'b1;
            s1_hi_d     = hi_sum;
            s1_lo_d     = lo_sel;
            s1_approx_d = bus.approx_en;
        end else if (s1_adv) begin
            s1_valid_d  = 1'b0;
        end

        // The approximate low part never exceeds the exact one, so W bits suffice.
        if (s1_adv) begin
            out_valid_d = 1'b1;
            z_d         = s1_hi_q + s1_lo_q;
            z_approx_d  = s1_approx_q;
        end else if (out_fire) begin
            out_valid_d = 1'b0;
        end

        if (out_fire && op_count_q != CNT_MAX) begin
            op_count_d = op_count_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s1_hi_q     <= '0;
            s1_lo_q     <= '0;
            s1_approx_q <= 1'b0;
            out_valid_q <= 1'b0;
            z_q         <= '0;
            z_approx_q  <= 1'b0;
            op_count_q  <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_hi_q     <= s1_hi_d;
            s1_lo_q     <= s1_lo_d;
            s1_approx_q <= s1_approx_d;
            out_valid_q <= out_valid_d;
            z_q         <= z_d;
            z_approx_q  <= z_approx_d;
            op_count_q  <= op_count_d;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.z         = z_q;
    assign bus.z_approx  = z_approx_q;
    assign bus.op_count  = op_count_q;
endmodule

// File: tb/tb_approx_mult_pipe.sv
// Bench for approx_mult_pipe: five instances (K = 0, 5, 8, 15 and a CW=4 copy)
// share one stimulus stream and are checked against a column-rule model.
module tb_approx_mult_pipe;
    localparam int N  = 8;
    localparam int NI = 5;

    typedef struct {
        logic [7:0]  x;
        logic [7:0]  y;
        logic        a;
        logic [15:0] z;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic in_valid = 1'b0;
    logic approx_en = 1'b0;
    logic out_ready = 1'b0;
    logic [7:0] x = '0;
    logic [7:0] y = '0;

    logic [NI-1:0] in_ready_a;
    logic [NI-1:0] out_valid_a;
    logic [NI-1:0] z_approx_a;
    logic [15:0]   z_a [NI];
    logic [15:0]   cnt_a [NI];

    int ks   [NI] = '{0, 5, 8, 15, 8};
    int cmax [NI] = '{65535, 65535, 65535, 65535, 15};

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        localparam int KG  = (g == 0) ? 0 : (g == 1) ? 5 : (g == 2) ? 8 : (g == 3) ? 15 : 8;
        localparam int CWG = (g == 4) ? 4 : 16;
        approx_mult_pipe_if #(.N(N), .CW(CWG)) bus ();
        assign bus.in_valid  = in_valid;
        assign bus.x         = x;
        assign bus.y         = y;
        assign bus.approx_en = approx_en;
        assign bus.out_ready = out_ready;
        assign in_ready_a[g]  = bus.in_ready;
        assign out_valid_a[g] = bus.out_valid;
        assign z_approx_a[g]  = bus.z_approx;
        assign z_a[g]         = bus.z;
        assign cnt_a[g]       = 16'(bus.op_count);
        approx_mult_pipe #(.N(N), .K(KG), .CW(CWG)) dut (
            .clk   (clk),
            .rst_n (rst_n),
            .bus   (bus)
        );
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference: every set partial-product bit goes to column i+j; columns below k
    // are ORed together, columns at or above k are added with full weight.
    function automatic logic [15:0] ref_z(input logic [7:0] xv, input logic [7:0] yv,
                                          input logic a, input int k);
        int hi = 0;
        int lo = 0;
        if (!a) return 16'(int'(xv) * int'(yv));
        for (int i = 0; i < 8; i++)
            for (int j = 0; j < 8; j++)
                if (xv[i] && yv[j]) begin
                    if (i + j >= k) hi = hi + (1 << (i + j));
                    else            lo = lo | (1 << (i + j));
                end
        return 16'(hi + lo);
    endfunction

    // ---------------- scoreboard ----------------
    logic [16:0] exp_q [$];
    int          acc_q [$];
    int          cnt_m [NI];
    logic        stall_prev = 1'b0;
    logic [15:0] z_prev [NI];
    logic        ov_e, ir_e;
    logic [16:0] f;

    always @(negedge clk) begin
        ov_e = (exp_q.size() > 0) && (cyc >= acc_q[0] + 1);
        ir_e = !rst_n || !(exp_q.size() == 2 && !out_ready);
        for (int g = 0; g < NI; g++)
            chk($sformatf("in_ready[%0d]", g), 64'(in_ready_a[g]), 64'(ir_e));
        if (!rst_n) begin
            exp_q.delete();
            acc_q.delete();
            for (int g = 0; g < NI; g++) cnt_m[g] = 0;
            stall_prev = 1'b0;
        end else begin
            f = (exp_q.size() > 0) ? exp_q[0] : '0;
            for (int g = 0; g < NI; g++) begin
                chk($sformatf("out_valid[%0d]", g), 64'(out_valid_a[g]), 64'(ov_e));
                chk($sformatf("op_count[%0d]", g), 64'(cnt_a[g]), 64'(cnt_m[g]));
                if (stall_prev)
                    chk($sformatf("z_held[%0d]", g), 64'(z_a[g]), 64'(z_prev[g]));
                if (ov_e && out_ready) begin
                    chk($sformatf("z[K=%0d,g=%0d]", ks[g], g), 64'(z_a[g]),
                        64'(ref_z(f[15:8], f[7:0], f[16], ks[g])));
                    chk($sformatf("z_approx[%0d]", g), 64'(z_approx_a[g]), 64'(f[16]));
                end
            end
            if (ov_e && out_ready) begin
                chk("k0_exact", 64'(z_a[0]), 64'(int'(f[15:8]) * int'(f[7:0])));
                void'(exp_q.pop_front());
                void'(acc_q.pop_front());
                for (int g = 0; g < NI; g++)
                    if (cnt_m[g] < cmax[g]) cnt_m[g]++;
            end
            if (in_valid && ir_e) begin
                exp_q.push_back({approx_en, x, y});
                acc_q.push_back(cyc + 1);
            end
            stall_prev = ov_e && !out_ready;
            for (int g = 0; g < NI; g++) z_prev[g] = z_a[g];
        end
    end

    // ---------------- driver tasks ----------------
    task automatic drive(input logic v, input logic [7:0] xv, input logic [7:0] yv, input logic a);
        in_valid = v; x = xv; y = yv; approx_en = a;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        in_valid = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    // ---------------- test sequence ----------------
    vec_t tbl [7];
    logic [15:0] got [$];
    int bi;
    int beats;
    logic acc;
    logic hold;
    int r;

    initial begin
        tbl[0] = '{8'd255, 8'd255, 1'b0, 16'd65025};
        tbl[1] = '{8'd255, 8'd255, 1'b1, 16'd63487};
        tbl[2] = '{8'd3,   8'd3,   1'b1, 16'd7};
        tbl[3] = '{8'd3,   8'd3,   1'b0, 16'd9};
        tbl[4] = '{8'd0,   8'd200, 1'b1, 16'd0};
        tbl[5] = '{8'd200, 8'd0,   1'b0, 16'd0};
        tbl[6] = '{8'd255, 8'd1,   1'b1, 16'd255};

        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        out_ready = 1'b1;

        // Table vectors on the K=8 instance, one beat at a time.
        for (int i = 0; i < 7; i++) begin
            drive(1'b1, tbl[i].x, tbl[i].y, tbl[i].a);
            step();
            in_valid = 1'b0;
            @(negedge clk);
            chk("tbl_not_yet_valid", 64'(out_valid_a[2]), 64'd0);
            @(negedge clk);
            chk("tbl_valid", 64'(out_valid_a[2]), 64'd1);
            chk($sformatf("tbl_z[%0d]", i), 64'(z_a[2]), 64'(tbl[i].z));
            chk($sformatf("tbl_za[%0d]", i), 64'(z_approx_a[2]), 64'(tbl[i].a));
            step();
        end

        // Back-to-back exact then approximate 255*255.
        drive(1'b1, 8'd255, 8'd255, 1'b0);
        step();
        drive(1'b1, 8'd255, 8'd255, 1'b1);
        step();
        in_valid = 1'b0;
        @(negedge clk);
        chk("b2b_first_z", 64'(z_a[2]), 64'd65025);
        chk("b2b_first_za", 64'(z_approx_a[2]), 64'd0);
        @(negedge clk);
        chk("b2b_second_z", 64'(z_a[2]), 64'd63487);
        chk("b2b_second_za", 64'(z_approx_a[2]), 64'd1);
        step();
        repeat (2) step();

        // Back-pressure: out_ready pattern 1,0,0 repeating.
        bi = 0;
        got.delete();
        for (int c = 0; c < 200 && got.size() < 6; c++) begin
            out_ready = (c % 3 == 0);
            drive(bi < 6, 8'(bi + 1), 8'd2, 1'b0);
            @(negedge clk);
            acc = in_valid && in_ready_a[2];
            if (out_valid_a[2] && out_ready) got.push_back(z_a[2]);
            step();
            if (acc) bi++;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        chk("bp_count", 64'(got.size()), 64'd6);
        for (int k = 0; k < 6 && k < got.size(); k++)
            chk($sformatf("bp_order[%0d]", k), 64'(got[k]), 64'(2 * (k + 1)));
        repeat (3) step();

        // Saturation of the 4-bit counter over 20 transfers.
        pulse_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
            step();
        end
        in_valid = 1'b0;
        repeat (4) step();
        @(negedge clk);
        chk("cw4_saturated", 64'(cnt_a[4]), 64'd15);
        chk("cw16_count20", 64'(cnt_a[2]), 64'd20);
        step();

        // Reset with two beats in flight; a beat offered during reset is ignored.
        drive(1'b1, 8'd10, 8'd11, 1'b0);
        step();
        drive(1'b1, 8'd20, 8'd21, 1'b1);
        step();
        rst_n = 1'b0;
        drive(1'b1, 8'd7, 8'd7, 1'b0);
        step();
        rst_n = 1'b1;
        drive(1'b1, 8'd12, 8'd13, 1'b0);
        @(negedge clk);
        chk("rst_out_valid", 64'(out_valid_a[2]), 64'd0);
        chk("rst_op_count", 64'(cnt_a[2]), 64'd0);
        step();
        in_valid = 1'b0;
        @(negedge clk);
        chk("post_rst_latency1", 64'(out_valid_a[2]), 64'd0);
        @(negedge clk);
        chk("post_rst_latency2", 64'(out_valid_a[2]), 64'd1);
        chk("post_rst_z", 64'(z_a[2]), 64'd156);
        step();
        repeat (2) step();

        // Random sweep with held-until-accepted beats and random back-pressure.
        beats = 0;
        hold = 1'b0;
        for (int c = 0; c < 60000 && beats < 10000; c++) begin
            if (!hold) begin
                in_valid = ($urandom_range(0, 3) != 0);
                r = $urandom_range(0, 9);
                x = (r == 0) ? 8'd0 : (r == 1) ? 8'd255 : 8'($urandom_range(0, 255));
                r = $urandom_range(0, 9);
                y = (r == 0) ? 8'd0 : (r == 1) ? 8'd255 : 8'($urandom_range(0, 255));
                approx_en = 1'($urandom_range(0, 1));
            end
            out_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            acc = in_valid && in_ready_a[2];
            step();
            if (acc) beats++;
            hold = in_valid && !acc;
        end
        chk("sweep_beats", 64'(beats), 64'd10000);
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 10 && exp_q.size() > 0; c++) step();
        chk("drain_empty", 64'(exp_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end
endmodule
